draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Draw scheduler: tracks the colour last drawn for each of 13 screen jobs
// (9 board cells plus winner, turn, tie and tie2 indicators) and issues a
// draw job to an external drawer whenever a job's target colour differs
// from what is on screen. Jobs are picked round-robin after the last one
// completed; a sticky error flags a drawer that never reports completion.
module draw_scheduler #(
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [17:0] ledr,
  input  logic [3:0]  winner,
  input  logic        tie,
  input  logic [1:0]  whose_turn,
  input  logic        refresh,
  input  logic        draw_ack,
  input  logic        draw_done,
  output logic        draw_req,
  output logic [7:0]  startx,
  output logic [6:0]  starty,
  output logic [2:0]  color,
  output logic [2:0]  selector,
  output logic [3:0]  job_id,
  output logic        busy,
  output logic        err
);

  localparam int NJOBS = 13;
  // Counter wide enough to hold TIMEOUT-1; at least one bit.
  localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [3:0] JOB_WINNER = 4'd9;
  localparam logic [3:0] JOB_TURN   = 4'd10;
  localparam logic [3:0] JOB_TIE    = 4'd11;
  localparam logic [3:0] JOB_TIE2   = 4'd12;
  localparam logic [3:0] LAST_JOB   = 4'd12;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    REQ       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [3:0]              ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NJOBS-1:0][2:0]   drawn_q, drawn_d;

  logic                    draw_req_q, draw_req_d;
  logic [7:0]              startx_q, startx_d;
  logic [6:0]              starty_q, starty_d;
  logic [2:0]              color_q, color_d;
  logic [2:0]              selector_q, selector_d;
  logic [3:0]              job_id_q, job_id_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  // ------------------------------------------------------------------
  // Target colours and dirty flags
  // ------------------------------------------------------------------
  logic [NJOBS-1:0][2:0]   target;
  logic [NJOBS-1:0]        dirty;

  // Two-bit player code to colour: player 1 green, player 2 blue, else white.
  function automatic logic [2:0] field_color(input logic [1:0] f);
    logic [2:0] c;
    case (f)
      2'b01:   c = 3'b010;
      2'b11:   c = 3'b001;
      default: c = 3'b111;
    endcase
    return c;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell_target
      // Cell k lives at ledr[17-2k:16-2k], row-major A1..C3.
      assign target[gi] = field_color(ledr[17-2*gi -: 2]);
    end
  endgenerate

  assign target[JOB_WINNER] = (winner == 4'b1011) ? 3'b010 :
                              (winner == 4'b1010) ? 3'b001 : 3'b111;
  assign target[JOB_TURN]   = field_color(whose_turn);
  assign target[JOB_TIE]    = tie ? 3'b010 : 3'b111;
  assign target[JOB_TIE2]   = tie ? 3'b001 : 3'b111;

  generate
    for (gi = 0; gi < NJOBS; gi++) begin : g_dirty
      assign dirty[gi] = (target[gi] != drawn_q[gi]);
    end
  endgenerate

  // ------------------------------------------------------------------
  // Job descriptor lookup
  // ------------------------------------------------------------------
  function automatic logic [7:0] job_x(input logic [3:0] j);
    logic [7:0] x;
    case (j)
      4'd0, 4'd3, 4'd6: x = 8'd4;
      4'd1, 4'd4, 4'd7: x = 8'd44;
      4'd2, 4'd5, 4'd8: x = 8'd84;
      default:          x = 8'd145;
    endcase
    return x;
  endfunction

  function automatic logic [6:0] job_y(input logic [3:0] j);
    logic [6:0] y;
    case (j)
      4'd0, 4'd1, 4'd2: y = 7'd4;
      4'd3, 4'd4, 4'd5: y = 7'd44;
      4'd6, 4'd7, 4'd8: y = 7'd84;
      JOB_WINNER:       y = 7'd70;
      JOB_TURN:         y = 7'd100;
      JOB_TIE:          y = 7'd90;
      JOB_TIE2:         y = 7'd80;
      default:          y = 7'd0;
    endcase
    return y;
  endfunction

  function automatic logic [2:0] job_sel(input logic [3:0] j);
    logic [2:0] s;
    case (j)
      JOB_WINNER, JOB_TURN: s = 3'b001;
      JOB_TIE:              s = 3'b011;
      JOB_TIE2:             s = 3'b100;
      default:              s = 3'b000;
    endcase
    return s;
  endfunction

  // (p + i) mod NJOBS for p <= 12 and 1 <= i <= 13: one conditional subtract.
  function automatic logic [3:0] wrap_idx(input logic [3:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NJOBS) s = s - NJOBS;
    return s[3:0];
  endfunction

  // ------------------------------------------------------------------
  // Round-robin pick
  // ------------------------------------------------------------------
  logic       pick_found;
  logic [3:0] pick_job;

  // Scan from farthest to nearest so the nearest dirty job after ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_job   = 4'd0;
    for (int i = NJOBS; i >= 1; i--) begin
      if (dirty[wrap_idx(ptr_q, i)]) begin
        pick_found = 1'b1;
        pick_job   = wrap_idx(ptr_q, i);
      end
    end
  end

  logic in_flight;
  assign in_flight = (state_q == REQ) || (state_q == WAIT_DONE);

  // ------------------------------------------------------------------
  // Next-state, drawn bookkeeping and registered-output values
  // ------------------------------------------------------------------
  // Handshake FSM plus drawn-colour updates from completion and refresh.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    drawn_d    = drawn_q;
    draw_req_d = draw_req_q;
    startx_d   = startx_q;
    starty_d   = starty_q;
    color_d    = color_q;
    selector_d = selector_q;
    job_id_d   = job_id_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (|dirty) state_d = SELECT;
      end

      SELECT: begin
        // Targets may have moved back in line with drawn since IDLE; in that
        // case there is nothing to issue and we simply go back to waiting.
        if (pick_found) begin
          job_id_d   = pick_job;
          startx_d   = job_x(pick_job);
          starty_d   = job_y(pick_job);
          selector_d = job_sel(pick_job);
          color_d    = target[pick_job];
          draw_req_d = 1'b1;
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        // draw_done here is ignored even when it arrives with draw_ack.
        if (draw_ack) begin
          draw_req_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (draw_done) begin
          // Record what was actually drawn; if the target moved meanwhile
          // the job stays dirty and comes round again.
          drawn_d[job_id_q] = color_q;
          ptr_d             = job_id_q;
          state_d           = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ptr_d   = job_id_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Refresh wipes the screen record, except for a job still with the
    // drawer: its completion will write its own colour.
    if (refresh) begin
      for (int j = 0; j < NJOBS; j++) begin
        if (!(in_flight && (job_id_q == 4'(j)))) drawn_d[j] = 3'b000;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      ptr_q      <= LAST_JOB;
      cnt_q      <= '0;
      drawn_q    <= '0;
      draw_req_q <= 1'b0;
      startx_q   <= 8'd0;
      starty_q   <= 7'd0;
      color_q    <= 3'd0;
      selector_q <= 3'd0;
      job_id_q   <= 4'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      drawn_q    <= drawn_d;
      draw_req_q <= draw_req_d;
      startx_q   <= startx_d;
      starty_q   <= starty_d;
      color_q    <= color_d;
      selector_q <= selector_d;
      job_id_q   <= job_id_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign draw_req = draw_req_q;
  assign startx   = startx_q;
  assign starty   = starty_q;
  assign color    = color_q;
  assign selector = selector_q;
  assign job_id   = job_id_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: table of single-job updates, hand-written
// handshake corner cases, then randomized traffic against a job model.
module tb_draw_scheduler;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        resetn;
  logic [17:0] ledr;
  logic [3:0]  winner;
  logic        tie;
  logic [1:0]  whose_turn;
  logic        refresh;
  logic        draw_ack;
  logic        draw_done;
  logic        draw_req;
  logic [7:0]  startx;
  logic [6:0]  starty;
  logic [2:0]  color;
  logic [2:0]  selector;
  logic [3:0]  job_id;
  logic        busy;
  logic        err;

  draw_scheduler #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ledr       (ledr),
    .winner     (winner),
    .tie        (tie),
    .whose_turn (whose_turn),
    .refresh    (refresh),
    .draw_ack   (draw_ack),
    .draw_done  (draw_done),
    .draw_req   (draw_req),
    .startx     (startx),
    .starty     (starty),
    .color      (color),
    .selector   (selector),
    .job_id     (job_id),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the screen holds per job, and where the scan resumes.
  int drawn_m[13];
  int ptr_m;
  int cur_job;
  int cur_color;

  typedef struct {
    logic [17:0] ledr;
    logic [3:0]  win;
    logic        tie;
    logic [1:0]  turn;
    int          job;   // -1: no job expected
    int          col;
    int          x;
    int          y;
    int          sel;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int map2(input int f);
    if (f == 1) return 2;
    if (f == 3) return 1;
    return 7;
  endfunction

  function automatic int target_m(input int j);
    int v;
    v = int'(ledr);
    if (j < 9)   return map2((v >> (16 - 2*j)) & 3);
    if (j == 9)  return (winner == 4'b1011) ? 2 : ((winner == 4'b1010) ? 1 : 7);
    if (j == 10) return map2(int'(whose_turn));
    if (j == 11) return tie ? 2 : 7;
    return tie ? 1 : 7;
  endfunction

  function automatic int exp_x(input int j);
    return (j < 9) ? 4 + 40*(j % 3) : 145;
  endfunction

  function automatic int exp_y(input int j);
    if (j < 9)   return 4 + 40*(j / 3);
    if (j == 9)  return 70;
    if (j == 10) return 100;
    if (j == 11) return 90;
    return 80;
  endfunction

  function automatic int exp_sel(input int j);
    if (j < 9)   return 0;
    if (j < 11)  return 1;
    if (j == 11) return 3;
    return 4;
  endfunction

  function automatic int next_job_m();
    for (int i = 1; i <= 13; i++) begin
      int j;
      j = (ptr_m + i) % 13;
      if (target_m(j) != drawn_m[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 13; j++) drawn_m[j] = 0;
    ptr_m = 12;
  endtask

  task automatic model_refresh(input bool_keep);
    for (int j = 0; j < 13; j++)
      if (!(bool_keep && j == cur_job)) drawn_m[j] = 0;
  endtask

  // Wait (bounded) for draw_req, then compare the descriptor.
  task automatic expect_issue(input string tag, input int j, input int col,
                              input int x, input int y, input int sel);
    int k = 0;
    while (draw_req !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    check({tag, " req_seen"}, int'(draw_req === 1'b1), 1);
    if (draw_req === 1'b1) begin
      check({tag, " job_id"}, int'(job_id), j);
      check({tag, " color"}, int'(color), col);
      check({tag, " startx"}, int'(startx), x);
      check({tag, " starty"}, int'(starty), y);
      check({tag, " selector"}, int'(selector), sel);
      $display("issue %s: job %0d color %0d at (%0d,%0d) sel %0d", tag,
               job_id, color, startx, starty, selector);
    end
    cur_job   = j;
    cur_color = col;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (draw_req !== 1'b0 || busy !== 1'b0) seen++;
    end
    check({tag, " quiet"}, seen, 0);
    $display("quiet %s: %0d active cycles in %0d", tag, seen, n);
  endtask

  // Acknowledge after dly extra cycles; optionally with a stray draw_done.
  task automatic do_ack(input int dly, input bit with_done);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("req_hold", int'(draw_req), 1);
      check("job_hold", int'(job_id), cur_job);
    end
    draw_ack  = 1'b1;
    draw_done = with_done;
    tick();
    draw_ack  = 1'b0;
    draw_done = 1'b0;
    check("req_drop", int'(draw_req), 0);
    check("busy_wait", int'(busy), 1);
  endtask

  // rmode: 0 none, 1 refresh with done, 2 refresh early in the wait.
  task automatic do_done(input int dly, input int rmode);
    for (int i = 0; i < dly; i++) begin
      if (rmode == 2 && i == 0) refresh = 1'b1;
      tick();
      refresh = 1'b0;
    end
    draw_done = 1'b1;
    if (rmode == 1) refresh = 1'b1;
    tick();
    draw_done = 1'b0;
    refresh   = 1'b0;
    check("busy_idle", int'(busy), 0);
    if (rmode != 0) model_refresh(1'b1);
    drawn_m[cur_job] = cur_color;
    ptr_m            = cur_job;
  endtask

  task automatic model_issue(input string tag, output bit got);
    int j;
    j   = next_job_m();
    got = 1'b0;
    if (j < 0) expect_quiet(tag, 6);
    else begin
      expect_issue(tag, j, target_m(j), exp_x(j), exp_y(j), exp_sel(j));
      got = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    bit got;
    for (int n = 0; n < 20; n++) begin
      if (next_job_m() < 0) break;
      model_issue(tag, got);
      do_ack(0, 1'b0);
      do_done(2, 0);
    end
    expect_quiet({tag, " end"}, 8);
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 3);
    case (r)
      0: begin
        int k;
        k = $urandom_range(0, 8);
        ledr[17-2*k -: 2] = 2'($urandom_range(0, 3));
      end
      1: winner = ($urandom_range(0, 2) == 0) ? 4'b1011 :
                  (($urandom_range(0, 1) == 0) ? 4'b1010 : 4'($urandom_range(0, 15)));
      2: whose_turn = 2'($urandom_range(0, 3));
      default: tie = ~tie;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit got;

    vecs[0] = '{18'h00100, 4'b0000, 1'b0, 2'b00,  4, 2, 44, 44, 0};
    vecs[1] = '{18'h30100, 4'b0000, 1'b0, 2'b00,  0, 1,  4,  4, 0};
    vecs[2] = '{18'h30100, 4'b1011, 1'b0, 2'b00,  9, 2, 145, 70, 1};
    vecs[3] = '{18'h30100, 4'b1010, 1'b0, 2'b00,  9, 1, 145, 70, 1};
    vecs[4] = '{18'h30100, 4'b1010, 1'b0, 2'b01, 10, 2, 145, 100, 1};
    vecs[5] = '{18'h30100, 4'b1010, 1'b0, 2'b11, 10, 1, 145, 100, 1};
    vecs[6] = '{18'h30101, 4'b1010, 1'b0, 2'b11,  8, 2, 84, 84, 0};
    vecs[7] = '{18'h33101, 4'b1010, 1'b0, 2'b11,  2, 1, 84,  4, 0};
    vecs[8] = '{18'h33121, 4'b1010, 1'b0, 2'b11, -1, 0,  0,  0, 0};
    vecs[9] = '{18'h33121, 4'b1111, 1'b0, 2'b11,  9, 7, 145, 70, 1};

    resetn     = 1'b0;
    ledr       = '0;
    winner     = '0;
    tie        = 1'b0;
    whose_turn = '0;
    refresh    = 1'b0;
    draw_ack   = 1'b0;
    draw_done  = 1'b0;
    cur_job    = 0;
    cur_color  = 0;
    model_reset();

    // Reset values
    repeat (3) tick();
    check("rst draw_req", int'(draw_req), 0);
    check("rst busy", int'(busy), 0);
    check("rst err", int'(err), 0);
    check("rst job_id", int'(job_id), 0);
    check("rst startx", int'(startx), 0);
    check("rst starty", int'(starty), 0);
    check("rst color", int'(color), 0);
    check("rst selector", int'(selector), 0);
    resetn = 1'b1;

    // After reset every job is dirty: 0..12 in order, all white.
    for (int j = 0; j < 13; j++) begin
      expect_issue("boot", j, 7, exp_x(j), exp_y(j), exp_sel(j));
      do_ack(0, 1'b0);
      do_done(4, 0);
    end
    expect_quiet("boot idle", 10);

    // Table: each entry from idle changes exactly one target (or none).
    for (int v = 0; v < 10; v++) begin
      ledr       = vecs[v].ledr;
      winner     = vecs[v].win;
      tie        = vecs[v].tie;
      whose_turn = vecs[v].turn;
      if (vecs[v].job < 0) expect_quiet("vec none", 10);
      else begin
        expect_issue("vec", vecs[v].job, vecs[v].col, vecs[v].x, vecs[v].y, vecs[v].sel);
        do_ack(1, 1'b0);
        do_done(3, 0);
      end
    end

    // Park ptr at 4, then cell 8 and tie together: 8, 11, 12.
    ledr = 18'h33321;
    expect_issue("p4", 4, 1, 44, 44, 0);
    do_ack(0, 1'b0);
    do_done(3, 0);
    ledr = 18'h33323;
    tie  = 1'b1;
    expect_issue("rr a", 8, 1, 84, 84, 0);
    do_ack(0, 1'b1);                 // done alongside ack must be ignored
    do_done(3, 0);
    expect_issue("rr b", 11, 2, 145, 90, 3);
    do_ack(0, 1'b0);
    do_done(3, 0);
    expect_issue("rr c", 12, 1, 145, 80, 4);
    do_ack(0, 1'b0);
    do_done(3, 0);
    expect_quiet("rr idle", 6);

    // Target changes while job 0 is in flight: reissued afterwards.
    ledr = 18'h03323;
    expect_issue("inflt", 0, 7, 4, 4, 0);
    do_ack(0, 1'b0);
    ledr = 18'h13323;
    do_done(3, 0);
    expect_issue("reiss", 0, 2, 4, 4, 0);
    do_ack(0, 1'b0);
    do_done(3, 0);
    tie = 1'b0;
    drain("untie");

    // Stray handshake pulses while idle.
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    draw_ack  = 1'b1;
    tick();
    draw_ack  = 1'b0;
    expect_quiet("stray", 6);

    // Timeout: drawer never completes job 1.
    ledr = 18'h17323;
    expect_issue("to", 1, 2, 44, 4, 0);
    do_ack(0, 1'b0);
    for (int m = 2; m <= 16; m++) begin
      tick();
      if (m == 15) begin
        check("to err early", int'(err), 0);
        check("to busy early", int'(busy), 1);
      end
      if (m == 16) begin
        check("to err set", int'(err), 1);
        check("to busy", int'(busy), 0);
      end
    end
    ptr_m = 1;
    expect_issue("to again", 1, 2, 44, 4, 0);
    do_ack(0, 1'b0);
    do_done(3, 0);
    check("err sticky", int'(err), 1);
    expect_quiet("to idle", 6);

    // Refresh while idle: all 13 redrawn starting after ptr.
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    model_refresh(1'b0);
    check("refresh first", next_job_m(), 2);
    drain("refresh");

    // Reset in the middle of a request.
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    model_refresh(1'b0);
    model_issue("prerst", got);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("rreq draw_req", int'(draw_req), 0);
    check("rreq busy", int'(busy), 0);
    check("rreq err", int'(err), 0);
    check("rreq job_id", int'(job_id), 0);
    check("rreq color", int'(color), 0);
    model_reset();
    drain("after rst");

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      model_issue("rnd", got);
      if (got) begin
        int rm;
        do_ack($urandom_range(0, 2), ($urandom_range(0, 4) == 0));
        if ($urandom_range(0, 2) == 0) rand_inputs();
        rm = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
        do_done($urandom_range(1, 6), rm);
      end
      rand_inputs();
      if ($urandom_range(0, 15) == 0) begin
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        model_refresh(1'b0);
      end
    end
    drain("rnd end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
